// File: rtl/debug_step_controller_if.sv
// Dump stream and core debug read port shared between the step controller and its consumers.
// Handshake: a dump word transfers on every fastclk edge where dump_valid && dump_ready; while
// dump_valid is high and no transfer has happened, dump_index and dump_data hold steady.
interface debug_step_controller_if;
  logic [4:0]  swith_select;
  logic [31:0] reg_read_data_1;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;

  modport master (
    output swith_select, dump_valid, dump_index, dump_data,
    input  reg_read_data_1, dump_ready
  );

  modport slave (
    input  swith_select, dump_valid, dump_index, dump_data,
    output reg_read_data_1, dump_ready
  );
endinterface

// File: rtl/debug_step_controller.sv
// Run/step sequencer: debounces switch_run into single cpu_step pulses, then walks the core
// debug read port over $s0-$s7, $t0-$t9 and streams each register out as a dump word.
module debug_step_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 2,
  parameter int STEP_CNT_W      = 16
) (
  input  logic                  fastclk,
  input  logic                  reset,
  input  logic                  switch_run,
  input  logic                  dump_req,
  debug_step_controller_if.master dbg,
  output logic                  cpu_step,
  output logic                  dump_busy,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic [2:0]            fsm_state
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES);
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, STEP, SELECT, SETTLE, PRESENT} state_t;

  state_t                state, state_next;
  logic                  sync_a, sync_b, deb;
  logic [DCW-1:0]        deb_cnt;
  logic                  step_pending;
  logic [4:0]            ptr;
  logic [SCW-1:0]        settle_cnt;
  logic [4:0]            sel_r, idx_r;
  logic [31:0]           data_r;
  logic                  valid_r;
  logic [STEP_CNT_W-1:0] step_cnt_r;
  logic                  deb_full, deb_rise, settle_done, handshake, last_word;

  // ptr 0-7 -> $s0-$s7 (16-23), 8-15 -> $t0-$t7 (8-15), 16-17 -> $t8-$t9 (24-25)
  function automatic logic [4:0] walk_reg(input logic [4:0] p);
    if (p < 5'd8)       return p + 5'd16;
    else if (p < 5'd16) return p;
    else                return p + 5'd8;
  endfunction

  assign deb_full    = (deb_cnt == DCW'(DEBOUNCE_CYCLES - 1));
  assign deb_rise    = deb_full && (sync_b != deb) && sync_b;
  assign settle_done = (settle_cnt == SCW'(SETTLE_CYCLES - 1));
  assign handshake   = valid_r && dbg.dump_ready;
  assign last_word   = (ptr == 5'd17);

  always_ff @(posedge fastclk) begin
    if (reset) begin
      sync_a       <= 1'b0;
      sync_b       <= 1'b0;
      deb          <= 1'b0;
      deb_cnt      <= '0;
      step_pending <= 1'b0;
    end else begin
      sync_a <= switch_run;
      sync_b <= sync_a;
      if (sync_b == deb) begin
        deb_cnt <= '0;
      end else if (deb_full) begin
        deb     <= sync_b;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      // A rise while a step is already pending is absorbed; the pending step covers it.
      if (deb_rise)           step_pending <= 1'b1;
      else if (state == STEP) step_pending <= 1'b0;
    end
  end

  always_ff @(posedge fastclk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (step_pending)  state_next = STEP;
        else if (dump_req) state_next = SELECT;
      end
      STEP:    state_next = SELECT;
      SELECT:  state_next = SETTLE;
      SETTLE:  if (settle_done) state_next = PRESENT;
      PRESENT: if (handshake) state_next = last_word ? IDLE : SELECT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge fastclk) begin
    if (reset) begin
      ptr        <= '0;
      settle_cnt <= '0;
      sel_r      <= '0;
      idx_r      <= '0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      step_cnt_r <= '0;
    end else begin
      case (state)
        STEP: begin
          step_cnt_r <= step_cnt_r + 1'b1;
          ptr        <= '0;
        end
        SELECT: begin
          sel_r      <= walk_reg(ptr);
          settle_cnt <= '0;
        end
        SETTLE: begin
          if (settle_done) begin
            data_r  <= dbg.reg_read_data_1;
            idx_r   <= sel_r;
            valid_r <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        PRESENT: begin
          if (handshake) begin
            valid_r <= 1'b0;
            ptr     <= last_word ? 5'd0 : ptr + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg.swith_select = sel_r;
  assign dbg.dump_valid   = valid_r;
  assign dbg.dump_index   = idx_r;
  assign dbg.dump_data    = data_r;
  assign cpu_step         = (state == STEP);
  assign dump_busy        = (state != IDLE);
  assign step_count       = step_cnt_r;
  assign fsm_state        = state;

endmodule
